// File: rtl/cpu_pkg.sv
// Shared RV32I definitions: datapath widths, ALU operation codes, opcode
// constants, immediate formats and the helpers that build them.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_t;

  // alt selects SUB/SRA; the caller decides whether funct7[5] may apply
  function automatic alu_op_t funct_to_alu(logic [2:0] funct3, logic alt);
    alu_op_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] build_imm(imm_fmt_t fmt, logic [31:0] instr);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: control bits, ALU operation, immediate,
// operand usage and illegal-opcode detection for one instruction word.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic [31:0] imm,
  output logic        alu_src_imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        branch,
  output logic        jump,
  output logic        rs1_used,
  output logic        rs2_used,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       writes_rd;
  imm_fmt_t   imm_fmt;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];

  // Opcode-driven control; unknown opcodes leave every control bit low
  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    writes_rd   = 1'b0;
    illegal     = 1'b0;
    imm_fmt     = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        alu_op    = funct_to_alu(funct3, funct7_b5);
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7 only exists for the shift-immediates; elsewhere it is imm bits
        alu_op      = funct_to_alu(funct3, funct7_b5 & (funct3 == 3'b101));
        alu_src_imm = 1'b1;
        rs1_used    = 1'b1;
        writes_rd   = 1'b1;
        imm_fmt     = IMM_I;
      end
      OPC_LOAD: begin
        alu_src_imm = 1'b1;
        mem_read    = 1'b1;
        rs1_used    = 1'b1;
        writes_rd   = 1'b1;
        imm_fmt     = IMM_I;
      end
      OPC_STORE: begin
        alu_src_imm = 1'b1;
        mem_write   = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        imm_fmt     = IMM_S;
      end
      OPC_BRANCH: begin
        alu_op   = ALU_SUB;
        branch   = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm_fmt  = IMM_B;
      end
      OPC_JAL: begin
        alu_src_imm = 1'b1;
        jump        = 1'b1;
        writes_rd   = 1'b1;
        imm_fmt     = IMM_J;
      end
      OPC_JALR: begin
        alu_src_imm = 1'b1;
        jump        = 1'b1;
        rs1_used    = 1'b1;
        writes_rd   = 1'b1;
        imm_fmt     = IMM_I;
      end
      OPC_LUI: begin
        alu_op      = ALU_PASS_B;
        alu_src_imm = 1'b1;
        writes_rd   = 1'b1;
        imm_fmt     = IMM_U;
      end
      OPC_AUIPC: begin
        alu_src_imm = 1'b1;
        writes_rd   = 1'b1;
        imm_fmt     = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign reg_write = writes_rd & (instr[11:7] != 5'd0);
  assign imm       = build_imm(imm_fmt, instr);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register-file read addressing,
// load-use bubble insertion, flush handling and the ID/EX register.
module decode_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [XLEN-1:0]       if_instr,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  id_stall,
  input  logic                  flush,
  output logic [REG_ADDR_W-1:0] rf_read_addr1,
  output logic [REG_ADDR_W-1:0] rf_read_addr2,
  input  logic [XLEN-1:0]       rf_read_data1,
  input  logic [XLEN-1:0]       rf_read_data2,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [3:0]            ex_alu_op,
  output logic                  ex_alu_src_imm,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_illegal
);

  logic                  ifid_valid;
  logic [XLEN-1:0]       ifid_instr;
  logic [XLEN-1:0]       ifid_pc;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;

  logic [3:0]      dec_alu_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_alu_src_imm;
  logic            dec_mem_read;
  logic            dec_mem_write;
  logic            dec_reg_write;
  logic            dec_branch;
  logic            dec_jump;
  logic            dec_rs1_used;
  logic            dec_rs2_used;
  logic            dec_illegal;

  logic load_use;
  logic issue;
  logic issue_ok;

  assign id_rs1        = ifid_instr[19:15];
  assign id_rs2        = ifid_instr[24:20];
  assign id_rd         = ifid_instr[11:7];
  assign rf_read_addr1 = id_rs1;
  assign rf_read_addr2 = id_rs2;

  instr_decoder u_instr_decoder (
    .instr       (ifid_instr),
    .alu_op      (dec_alu_op),
    .imm         (dec_imm),
    .alu_src_imm (dec_alu_src_imm),
    .mem_read    (dec_mem_read),
    .mem_write   (dec_mem_write),
    .reg_write   (dec_reg_write),
    .branch      (dec_branch),
    .jump        (dec_jump),
    .rs1_used    (dec_rs1_used),
    .rs2_used    (dec_rs2_used),
    .illegal     (dec_illegal)
  );

  // A load in EX whose destination feeds an operand actually read in ID
  assign load_use = ifid_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                    ((dec_rs1_used & (ex_rd == id_rs1)) |
                     (dec_rs2_used & (ex_rd == id_rs2)));

  // Flush discards the waiting instruction, so holding fetch would be pointless
  assign id_stall = load_use & ~flush;
  assign issue    = ifid_valid & ~flush & ~load_use;
  assign issue_ok = issue & ~dec_illegal;

  // IF/ID register: capture whenever not stalled; a flush kills the new entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (!id_stall) begin
      ifid_valid <= if_valid & ~flush;
      ifid_instr <= if_instr;
      ifid_pc    <= if_pc;
    end
  end

  // ID/EX register: control is gated to zero for bubbles and illegal opcodes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid       <= 1'b0;
      ex_illegal     <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_alu_op      <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
    end else begin
      ex_valid       <= issue_ok;
      ex_illegal     <= issue & dec_illegal;
      ex_pc          <= ifid_pc;
      ex_rs1_data    <= rf_read_data1;
      ex_rs2_data    <= rf_read_data2;
      ex_imm         <= dec_imm;
      ex_rs1         <= id_rs1;
      ex_rs2         <= id_rs2;
      ex_rd          <= id_rd;
      ex_alu_op      <= issue_ok ? dec_alu_op : 4'd0;
      ex_alu_src_imm <= issue_ok & dec_alu_src_imm;
      ex_mem_read    <= issue_ok & dec_mem_read;
      ex_mem_write   <= issue_ok & dec_mem_write;
      ex_reg_write   <= issue_ok & dec_reg_write;
      ex_branch      <= issue_ok & dec_branch;
      ex_jump        <= issue_ok & dec_jump;
    end
  end

endmodule
